// File: rtl/ft601_tx_ctrl.sv
// rtl/ft601_tx_ctrl.sv - FT601 245-mode host-bound burst controller
// Prefetches capture-FIFO words into a 3-deep buffer and streams them out in capped bursts.
module ft601_tx_ctrl #(
  parameter int DATA_LEN   = 32,
  parameter int MAX_BURST  = 1024,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_LEN-1:0]   fifo_data,
  output logic                  fifo_rd_en_n,
  input  logic                  ft_txe_n,
  output logic [DATA_LEN-1:0]   ft_data,
  output logic [DATA_LEN/8-1:0] ft_be,
  output logic                  ft_wr_n,
  output logic                  ft_oe_n,
  output logic                  ft_rd_n,
  output logic                  busy,
  output logic [31:0]           words_sent
);

  localparam int BE_LEN = DATA_LEN / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [DATA_LEN-1:0] buf_mem [0:2];
  logic [1:0]          head_ptr;
  logic [1:0]          tail_ptr;
  logic [1:0]          occ;
  logic                inflight;
  logic [16:0]         burst_cnt;
  logic [7:0]          gap_cnt;

  logic                accept;
  logic                fetch;
  logic                push;
  logic [1:0]          occ_after_pop;
  logic [1:0]          occ_next;
  logic [1:0]          head_after_pop;
  logic [16:0]         burst_cnt_post;
  logic [DATA_LEN-1:0] head_next_data;
  logic                burst_end;
  logic                wr_n_next;
  logic                data_load;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A word leaves the buffer only when the strobe is already on the bus and the FT601 takes it.
  assign accept         = ~ft_wr_n & ~ft_txe_n;
  assign push           = inflight;
  assign fetch          = (state == S_BURST) && enable && !fifo_empty &&
                          (({1'b0, occ} + {2'b00, inflight}) <= 3'd2);
  assign occ_after_pop  = occ - {1'b0, accept};
  assign occ_next       = occ_after_pop + {1'b0, push};
  assign head_after_pop = accept ? ptr_inc(head_ptr) : head_ptr;
  assign head_next_data = (occ_after_pop != 2'd0) ? buf_mem[head_after_pop] : fifo_data;
  assign burst_cnt_post = burst_cnt + {16'd0, accept};

  // End conditions look at the buffer after this cycle's pop/push and this cycle's fetch.
  assign burst_end = (burst_cnt_post == 17'(MAX_BURST)) ||
                     ft_txe_n ||
                     ((occ_next == 2'd0) && !fetch && fifo_empty) ||
                     (!enable && (occ_next == 2'd0) && !fetch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (enable && !ft_txe_n && ((occ != 2'd0) || !fifo_empty)) begin
          state_next = S_BURST;
        end
      end
      S_BURST: begin
        if (burst_end) begin
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == 8'd1) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wr_n_next = 1'b1;
    data_load = 1'b0;
    case (state)
      S_BURST: begin
        data_load = (occ_next != 2'd0);
        wr_n_next = burst_end || (occ_next == 2'd0);
      end
      default: begin
        wr_n_next = 1'b1;
        data_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ        <= 2'd0;
      head_ptr   <= 2'd0;
      tail_ptr   <= 2'd0;
      inflight   <= 1'b0;
      burst_cnt  <= 17'd0;
      gap_cnt    <= 8'd0;
      ft_wr_n    <= 1'b1;
      ft_be      <= {BE_LEN{1'b0}};
      ft_data    <= {DATA_LEN{1'b0}};
      words_sent <= 32'd0;
    end else begin
      inflight <= fetch;
      occ      <= occ_next;
      head_ptr <= head_after_pop;
      if (push) begin
        tail_ptr <= ptr_inc(tail_ptr);
      end
      if ((state == S_IDLE) && (state_next == S_BURST)) begin
        burst_cnt <= 17'd0;
      end else if (accept) begin
        burst_cnt <= burst_cnt_post;
      end
      if ((state == S_BURST) && burst_end) begin
        gap_cnt <= 8'(GAP_CYCLES);
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
      ft_wr_n <= wr_n_next;
      ft_be   <= wr_n_next ? {BE_LEN{1'b0}} : {BE_LEN{1'b1}};
      if (data_load) begin
        ft_data <= head_next_data;
      end
      if (accept) begin
        words_sent <= words_sent + 32'd1;
      end
    end
  end

  // Storage needs no reset: occ and the pointers decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[tail_ptr] <= fifo_data;
    end
  end

  assign fifo_rd_en_n = ~fetch;
  assign ft_oe_n      = 1'b1;
  assign ft_rd_n      = 1'b1;
  assign busy         = (state != S_IDLE) || (occ != 2'd0);

endmodule
